// File: rtl/rect_finder.sv
// Scans a captured ROWS x COLS bit matrix for axis-aligned rectangles whose four corners are all 1.
// Optional macro RECT_FINDER_COUNT_EN enables the saturating rect_count counter (tied to 0 otherwise).
module rect_finder #(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ROWS*COLS-1:0]      m_in,
    output logic                      busy,
    output logic                      found_valid,
    input  logic                      found_ready,
    output logic [$clog2(ROWS)-1:0]   r1,
    output logic [$clog2(ROWS)-1:0]   r2,
    output logic [$clog2(COLS)-1:0]   c1,
    output logic [$clog2(COLS)-1:0]   c2,
    output logic                      done,
    output logic [15:0]               rect_count
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int N  = ROWS * COLS;

    localparam logic [RW-1:0] R_MAX = RW'(ROWS - 1);
    localparam logic [RW-1:0] R_PEN = RW'(ROWS - 2);
    localparam logic [CW-1:0] C_MAX = CW'(COLS - 1);
    localparam logic [CW-1:0] C_PEN = CW'(COLS - 2);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD, DONE} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    mat;
    logic [RW-1:0]   cr1, cr2, nr1, nr2;
    logic [CW-1:0]   cc1, cc2, nc1, nc2;
    logic            grid [ROWS][COLS];
    logic            hit;
    logic            last;
    logic            accept;
    logic            advance;

    // Element (r,c) lives at bit N-1-(r*COLS+c): row 0, column 0 is the MSB.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            assign grid[gr][gc] = mat[N-1-(gr*COLS+gc)];
        end
    end

    assign hit    = grid[cr1][cc1] & grid[cr1][cc2] & grid[cr2][cc1] & grid[cr2][cc2];
    assign last   = (cr1 == R_PEN) && (cr2 == R_MAX) && (cc1 == C_PEN) && (cc2 == C_MAX);
    assign accept = (state == HOLD) && found_ready;
    assign advance = ((state == SCAN) && !hit && !last) || (accept && !last);

    // Lexicographic successor: c2 fastest, then c1, r2, r1.
    always_comb begin
        nr1 = cr1;
        nr2 = cr2;
        nc1 = cc1;
        nc2 = cc2;
        if (cc2 != C_MAX) begin
            nc2 = cc2 + 1'b1;
        end else if (cc1 != C_PEN) begin
            nc1 = cc1 + 1'b1;
            nc2 = cc1 + CW'(2);
        end else begin
            nc1 = '0;
            nc2 = CW'(1);
            if (cr2 != R_MAX) begin
                nr2 = cr2 + 1'b1;
            end else begin
                nr1 = cr1 + 1'b1;
                nr2 = cr1 + RW'(2);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        busy        = (state != IDLE);
        found_valid = (state == HOLD);
        done        = (state == DONE);
        r1          = '0;
        r2          = '0;
        c1          = '0;
        c2          = '0;
        unique case (state)
            IDLE: if (start) state_nxt = SCAN;
            SCAN: begin
                if (hit)       state_nxt = HOLD;
                else if (last) state_nxt = DONE;
            end
            HOLD: begin
                r1 = cr1;
                r2 = cr2;
                c1 = cc1;
                c2 = cc2;
                if (found_ready) state_nxt = last ? DONE : SCAN;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mat   <= '0;
            cr1   <= '0;
            cr2   <= '0;
            cc1   <= '0;
            cc2   <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && start) begin
                mat <= m_in;
                cr1 <= '0;
                cr2 <= RW'(1);
                cc1 <= '0;
                cc2 <= CW'(1);
            end else if (advance) begin
                cr1 <= nr1;
                cr2 <= nr2;
                cc1 <= nc1;
                cc2 <= nc2;
            end
        end
    end

`ifdef RECT_FINDER_COUNT_EN
    logic [15:0] cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if ((state == IDLE) && start) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= sat_inc(cnt);
        end
    end

    assign rect_count = cnt;
`else
    assign rect_count = '0;
`endif

endmodule

// File: tb/tb_rect_finder.sv
// Directed, table-driven bench for rect_finder (4x4); rect_count expectations follow RECT_FINDER_COUNT_EN.
module tb_rect_finder;

`ifdef RECT_FINDER_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] m_in;
    logic        busy;
    logic        found_valid;
    logic        found_ready;
    logic [1:0]  r1, r2, c1, c2;
    logic        done;
    logic [15:0] rect_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rect_finder #(.ROWS(4), .COLS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .m_in       (m_in),
        .busy       (busy),
        .found_valid(found_valid),
        .found_ready(found_ready),
        .r1         (r1),
        .r2         (r2),
        .c1         (c1),
        .c2         (c2),
        .done       (done),
        .rect_count (rect_count)
    );

    typedef struct {
        logic [15:0] m;
        int          hits;
        logic [7:0]  first;
        logic [7:0]  last;
        string       name;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] cur_key();
        return {r1, r2, c1, c2};
    endfunction

    task automatic run_scan(input string nm, input logic [15:0] m, input int exp_hits,
                            input logic [7:0] exp_first, input logic [7:0] exp_last);
        int         hits = 0;
        int         busy_cnt = 0;
        int         done_cnt = 0;
        int         done_cyc = -1;
        int         cnt_bad = 0;
        int         order_bad = 0;
        int         idx_bad = 0;
        bit         fin = 1'b0;
        logic [7:0] first = '0;
        logic [7:0] lst = '0;
        logic [7:0] prev = '0;
        logic [7:0] cur;
        found_ready = 1'b1;
        m_in  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        m_in  = ~m;
        for (int k = 1; k < 200; k++) begin
            if (rect_count != (CNT_EN ? 16'(hits) : 16'd0)) cnt_bad++;
            if (busy) busy_cnt++;
            if (found_valid) begin
                cur = cur_key();
                if (hits == 0) first = cur;
                else if (cur <= prev) order_bad++;
                prev = cur;
                lst  = cur;
                hits++;
            end else if (cur_key() != 8'h00) begin
                idx_bad++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = k;
            end
            if (!busy) begin
                fin = 1'b1;
                break;
            end
            tick();
        end
        check({nm, " finished"}, int'(fin), 1);
        check({nm, " hits"}, hits, exp_hits);
        if (exp_hits > 0) begin
            check({nm, " first"}, int'(first), int'(exp_first));
            check({nm, " last"}, int'(lst), int'(exp_last));
        end
        check({nm, " done pulses"}, done_cnt, 1);
        check({nm, " done cycle"}, done_cyc, 37 + exp_hits);
        check({nm, " busy cycles"}, busy_cnt, 37 + exp_hits);
        check({nm, " final count"}, int'(rect_count), CNT_EN ? exp_hits : 0);
        check({nm, " count track"}, cnt_bad, 0);
        check({nm, " order"}, order_bad, 0);
        check({nm, " idx zero"}, idx_bad, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         bad;
        int         extra;
        bit         seen;
        logic [7:0] snap;

        tbl[0] = '{16'h0000,  0, 8'h00, 8'h00, "zero"};
        tbl[1] = '{16'h0A0A,  1, 8'h72, 8'h72, "0a0a"};
        tbl[2] = '{16'hFFFF, 36, 8'h11, 8'hBB, "ffff"};
        tbl[3] = '{16'hF00F,  6, 8'h31, 8'h3B, "f00f"};
        tbl[4] = '{16'h9009,  1, 8'h33, 8'h33, "9009"};
        tbl[5] = '{16'h6600,  1, 8'h16, 8'h16, "6600"};
        tbl[6] = '{16'h8001,  0, 8'h00, 8'h00, "8001"};
        tbl[7] = '{16'hCCC0,  3, 8'h11, 8'h61, "ccc0"};

        rst = 1'b1;
        start = 1'b0;
        found_ready = 1'b0;
        m_in = 16'h0;
        tick();
        tick();
        rst = 1'b0;
        check("reset busy", int'(busy), 0);
        check("reset found_valid", int'(found_valid), 0);
        check("reset done", int'(done), 0);
        check("reset idx", int'(cur_key()), 0);
        check("reset count", int'(rect_count), 0);

        for (int i = 0; i < 8; i++) begin
            run_scan(tbl[i].name, tbl[i].m, tbl[i].hits, tbl[i].first, tbl[i].last);
            tick();
        end

        // Stall in HOLD: indices stable, start and m_in changes ignored.
        found_ready = 1'b0;
        m_in = 16'h0A0A;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 60 && !found_valid; k++) tick();
        check("stall reach hold", int'(found_valid), 1);
        check("stall rect", int'(cur_key()), 8'h72);
        snap = cur_key();
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            m_in  = 16'hFFFF;
            start = k[0];
            tick();
            if (!found_valid || cur_key() != snap || !busy) bad++;
        end
        start = 1'b0;
        check("stall stable", bad, 0);
        check("stall count", int'(rect_count), 0);
        found_ready = 1'b1;
        tick();
        check("stall accept fv", int'(found_valid), 0);
        check("stall accept busy", int'(busy), 1);
        extra = 0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (found_valid) extra++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("stall done seen", int'(seen), 1);
        check("stall extra hits", extra, 0);
        tick();
        check("stall idle", int'(busy), 0);
        check("stall final count", int'(rect_count), CNT_EN ? 1 : 0);

        // Reset while holding a rectangle, with start and found_ready also high.
        found_ready = 1'b0;
        m_in = 16'hFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 60 && !found_valid; k++) tick();
        check("rst reach hold", int'(found_valid), 1);
        rst = 1'b1;
        start = 1'b1;
        found_ready = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check("rst busy", int'(busy), 0);
        check("rst found_valid", int'(found_valid), 0);
        check("rst done", int'(done), 0);
        check("rst idx", int'(cur_key()), 0);
        check("rst count", int'(rect_count), 0);
        tick();
        check("rst stays idle", int'(busy), 0);
        run_scan("after rst", 16'h0000, 0, 8'h00, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rect_finder.md
RECT_FINDER -- requirements
Module: rect_finder

Interface
REQ-001 SHALL have parameter ROWS, default 4, matrix row count (>=2).
REQ-002 SHALL have parameter COLS, default 4, matrix column count (>=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request to scan m_in.
REQ-006 SHALL have port m_in  input  ROWS*COLS  matrix; element (r,c) at bit ROWS*COLS-1-(r*COLS+c).
REQ-007 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-008 SHALL have port found_valid  output  1  rectangle corners valid on r1/r2/c1/c2.
REQ-009 SHALL have port found_ready  input  1  consumer accepts the current rectangle.
REQ-010 SHALL have ports r1, r2  output  $clog2(ROWS) each  rectangle rows, r1<r2.
REQ-011 SHALL have ports c1, c2  output  $clog2(COLS) each  rectangle columns, c1<c2.
REQ-012 SHALL have port done  output  1  one-cycle pulse, scan complete.
REQ-013 SHALL have port rect_count  output  16  rectangles accepted in current or last scan.

Function
REQ-014 SHALL implement states IDLE, SCAN, HOLD, DONE.
REQ-015 SHALL, in IDLE with start=1, register m_in into an internal copy, clear rect_count, load candidate (0,1,0,1), and enter SCAN next cycle.
REQ-016 SHALL ignore start in every state other than IDLE; m_in changes after capture have no effect.
REQ-017 SHALL evaluate exactly one candidate (r1,r2,c1,c2) per SCAN cycle; hit = all four corner bits of the captured copy are 1.
REQ-018 SHALL enumerate candidates lexicographically: c2 fastest, then c1, r2, r1; r2 in r1+1..ROWS-1, c2 in c1+1..COLS-1; C(ROWS,2)*C(COLS,2) candidates total (36 for 4x4).
REQ-019 SHALL, on a hit, enter HOLD next cycle with found_valid=1 and r1/r2/c1/c2 equal to the hit candidate.
REQ-020 SHALL hold found_valid and indices stable in HOLD until found_valid&&found_ready at a rising edge.
REQ-021 SHALL, on acceptance, advance to the next candidate and return to SCAN, or go to DONE if the hit was the last candidate.
REQ-022 SHALL, on a miss at the last candidate, go to DONE; otherwise advance the candidate and stay in SCAN.
REQ-023 SHALL assert done for exactly the one DONE cycle, then return to IDLE.
REQ-024 SHALL hold rect_count from DONE until the next accepted start; rect_count saturates at 16'hFFFF.
REQ-025 SHALL drive r1/r2/c1/c2 to 0 whenever found_valid=0.
REQ-026 SHALL keep indices directly compatible with the team's corner-flip block (same bit mapping, same index widths).

Reset
REQ-027 SHALL, when rst=1 at a rising edge (including mid-scan or in HOLD), enter IDLE and force busy=0, found_valid=0, done=0, r1=r2=c1=c2=0, rect_count=0, and clear the captured matrix.
REQ-028 SHALL give rst priority over start and found_ready in the same cycle.

Configuration
REQ-029 SHALL, with macro RECT_FINDER_COUNT_EN defined, increment rect_count by 1 on each HOLD acceptance.
REQ-030 SHALL, without RECT_FINDER_COUNT_EN, tie rect_count to 0 and include no counter logic; all other behaviour is unchanged.

Verification
REQ-031 SHALL cover: 4x4, m_in=16'h0000, start at edge 0 -> busy for SCAN cycles 1-36, no found_valid, done=1 in cycle 37, rect_count=0.
REQ-032 SHALL cover: m_in=16'h0A0A, found_ready=1 -> exactly one found_valid with (r1,r2,c1,c2)=(1,3,0,2), then done; rect_count=1 with RECT_FINDER_COUNT_EN.
REQ-033 SHALL cover: m_in=16'hFFFF, found_ready=1 -> 36 rectangles, first (0,1,0,1), last (2,3,2,3), rect_count=36.
REQ-034 SHALL cover: m_in=16'h0A0A, found_ready=0 for 5 cycles -> found_valid and indices stable through those cycles; start pulses and m_in changes during HOLD are ignored.
REQ-035 SHALL cover: m_in=16'hFFFF, rst=1 in HOLD -> next cycle all outputs 0, state IDLE; a new start with 16'h0000 completes normally.
REQ-036 SHALL cover: a build without RECT_FINDER_COUNT_EN running the 16'hFFFF scan -> rect_count=0 throughout, handshake identical to REQ-033.
